pixel_plotter: RTL
==================

# pixel_plotter

Consumes the (x, y) pixel stream produced by the line-drawing stage, buffers it, clips it to the visible frame, and converts each pixel to a linear framebuffer write. Sits between the line drawer and the framebuffer memory port. Absorbs framebuffer back-pressure through a small FIFO, and provides a full-frame clear sweep so the display can be blanked between drawings.

## Interface

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- ADDR_W, 19, framebuffer address width (must hold H_RES*V_RES-1)
- COLOR_W, 1, pixel colour width
- FIFO_DEPTH, 4, ingress FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pix_valid  in  1  upstream pixel present
- pix_ready  out  1  FIFO can accept a pixel
- pix_x  in  11  pixel column
- pix_y  in  11  pixel row
- pix_color  in  COLOR_W  pixel colour
- clear_start  in  1  one-cycle pulse requesting a frame clear
- fb_req  out  1  framebuffer write request
- fb_gnt  in  1  framebuffer accepts current request this cycle
- fb_addr  out  ADDR_W  write address
- fb_data  out  COLOR_W  write data
- busy  out  1  FIFO non-empty, request pending, or clear in progress
- clip_count  out  16  pixels dropped by clipping

## Operation

- Transfer in: a pixel is accepted on any edge where pix_valid && pix_ready. pix_ready = !fifo_full && state==S_RUN, so there is no push on full, even with a simultaneous pop.
- Compute stage pops the FIFO when the output register is free or is being granted this cycle. It computes addr = pix_y*H_RES + pix_x in ADDR_W bits and loads fb_addr/fb_data, then raises fb_req.
- Output register: fb_req, fb_addr and fb_data hold stable until an edge with fb_gnt=1. fb_gnt while fb_req=0 is ignored.
- FSM states:
  - S_RUN (reset state): normal plotting. S_RUN→S_CLEAR on clear_start when busy=0; clear_start while busy=1 is dropped.
  - S_CLEAR: a sweep counter issues addresses 0..H_RES*V_RES-1 with fb_data=0, using the same req/gnt rule. After the final grant it returns to S_RUN. pix_ready=0 throughout.
- Reset (any time, asynchronous): FIFO emptied, in-flight request abandoned, state S_RUN.
- Reset values: fb_req=0, fb_addr=0, fb_data=0, busy=0, clip_count=0. pix_ready=0 while reset is asserted, and 1 from the first edge after release.

## Timing

- Latency: pixel accepted at edge N → fb_req=1 with its address after edge N+2. There is no FIFO bypass.
- Throughput: one pixel per cycle sustained when fb_gnt is tied high.
- A clipped pixel consumes one compute-stage cycle and produces no fb_req.
- Clear of the default frame takes 307200 granted cycles. busy falls the cycle after the last grant.
- Empty FIFO plus output granted: fb_req falls after that edge.

## Configuration

- PIXEL_CLIP_EN defined:
  - Pixels with pix_x ≥ H_RES or pix_y ≥ V_RES are dropped at the compute stage.
  - clip_count increments once per dropped pixel and saturates at 16'hFFFF.
- PIXEL_CLIP_EN undefined:
  - No range check; the address is the truncated ADDR_W product.
  - clip_count is tied to 0.

## Structure

- Package pixel_pkg holds the H_RES/V_RES/ADDR_W defaults, the FRAME_PIXELS constant, and the plot_state_t enum (S_RUN, S_CLEAR).
- Sub-module pixel_fifo: synchronous FIFO, async active-low reset, with push/pop/full/empty and registered read data. The top level contains the compute stage, output register, FSM and sweep counter.

## Test plan

- fb_gnt tied 1; push (1,1), (2,1), (3,2) back-to-back → fb_addr 641, 642, 1283 on consecutive cycles, the first fb_req high after edge N+2.
- fb_gnt held 0 for 10 cycles while pushing 6 pixels:
  - pix_ready falls after 4 FIFO entries + 1 in the output register.
  - fb_addr stays stable.
  - all 6 pixels are written in order once fb_gnt=1.
- With PIXEL_CLIP_EN defined, push (640,0), (0,480), (639,479) → only addr 307199 is written; clip_count=2.
- clear_start while idle, fb_gnt=1:
  - 307200 writes of data 0, addresses 0..307199.
  - pix_ready=0 throughout.
  - busy drops after the last grant.
  - A clear_start while busy is ignored.
- Assert reset mid-stream with fb_req=1 → fb_req, busy and clip_count go 0 immediately, and the FIFO is empty after release.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared defaults, frame size and plotter state encoding for the pixel plotter slice.
package pixel_pkg;

    localparam int unsigned H_RES_DEF    = 640;
    localparam int unsigned V_RES_DEF    = 480;
    localparam int unsigned ADDR_W_DEF   = 19;
    localparam int unsigned FRAME_PIXELS = H_RES_DEF * V_RES_DEF;
    localparam int unsigned COORD_W      = 11;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } plot_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Ingress FIFO for plotter pixels: async active-low reset, registered read data,
// rd_valid marks when rd_data holds the head entry and a pop is allowed.
module pixel_fifo #(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned  PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && rd_valid_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[wptr_q] = wr_data;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
        // Head is read from the pre-write array, so an entry written on this edge
        // into the head slot becomes visible one edge later.
        rd_data_d  = mem_q[rptr_d];
        rd_valid_d = (count_d != '0) && !(push_ok && (wptr_q == rptr_d));
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: rtl/pixel_plotter.sv
// Buffers line-drawer pixels, converts them to linear framebuffer writes and runs the
// full-frame clear sweep. Define PIXEL_CLIP_EN to drop off-frame pixels and count them.
module pixel_plotter
    import pixel_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned COLOR_W    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [10:0]        pix_x,
    input  logic [10:0]        pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               clear_start,
    output logic               fb_req,
    input  logic               fb_gnt,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               busy,
    output logic [15:0]        clip_count
);

    localparam int unsigned       PIX_W     = 2 * COORD_W + COLOR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    plot_state_t        state_q, state_d;
    logic               fb_req_q, fb_req_d;
    logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0] fb_data_q, fb_data_d;
    logic [ADDR_W-1:0]  sweep_q, sweep_d;
    logic               sweep_done_q, sweep_done_d;
    logic               alive_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_rd_valid;
    logic [PIX_W-1:0]   fifo_wdata;
    logic [PIX_W-1:0]   fifo_rdata;
    logic [10:0]        fifo_x;
    logic [10:0]        fifo_y;
    logic [COLOR_W-1:0] fifo_color;
    logic [ADDR_W-1:0]  pix_addr;
    logic               pix_in_frame;
    logic               out_free;

    assign fifo_wdata = {pix_y, pix_x, pix_color};
    assign fifo_y     = fifo_rdata[PIX_W-1 -: COORD_W];
    assign fifo_x     = fifo_rdata[COLOR_W +: COORD_W];
    assign fifo_color = fifo_rdata[COLOR_W-1:0];
    assign pix_addr   = ADDR_W'(32'(fifo_y) * H_RES + 32'(fifo_x));

    assign out_free  = !fb_req_q || fb_gnt;
    assign pix_ready = alive_q && !fifo_full && (state_q == S_RUN);
    assign fifo_push = pix_valid && pix_ready;
    assign fifo_pop  = (state_q == S_RUN) && fifo_rd_valid && out_free;
    assign busy      = !fifo_empty || fb_req_q || (state_q == S_CLEAR);

    assign fb_req  = fb_req_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;

    pixel_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .wr_data  (fifo_wdata),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_valid (fifo_rd_valid),
        .rd_data  (fifo_rdata)
    );

`ifdef PIXEL_CLIP_EN
    logic [15:0] clip_count_q, clip_count_d;

    assign pix_in_frame = (32'(fifo_x) < H_RES) && (32'(fifo_y) < V_RES);
    assign clip_count   = clip_count_q;

    always_comb begin
        clip_count_d = clip_count_q;
        if (fifo_pop && !pix_in_frame && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end
`else
    assign pix_in_frame = 1'b1;
    assign clip_count   = '0;
`endif

    always_comb begin
        state_d      = state_q;
        fb_req_d     = fb_req_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        sweep_d      = sweep_q;
        sweep_done_d = sweep_done_q;
        if (fb_req_q && fb_gnt) begin
            fb_req_d = 1'b0;
        end
        unique case (state_q)
            S_RUN: begin
                if (fifo_pop && pix_in_frame) begin
                    fb_req_d  = 1'b1;
                    fb_addr_d = pix_addr;
                    fb_data_d = fifo_color;
                end
                if (clear_start && !busy) begin
                    state_d      = S_CLEAR;
                    sweep_d      = '0;
                    sweep_done_d = 1'b0;
                end
            end
            S_CLEAR: begin
                // Leaving the sweep needs the final address granted, not just issued.
                if (out_free) begin
                    if (sweep_done_q) begin
                        state_d = S_RUN;
                    end else begin
                        fb_req_d  = 1'b1;
                        fb_addr_d = sweep_q;
                        fb_data_d = '0;
                        if (sweep_q == LAST_ADDR) begin
                            sweep_done_d = 1'b1;
                        end else begin
                            sweep_d = sweep_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_RUN;
            fb_req_q     <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            sweep_q      <= '0;
            sweep_done_q <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fb_req_q     <= fb_req_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            sweep_q      <= sweep_d;
            sweep_done_q <= sweep_done_d;
            alive_q      <= 1'b1;
        end
    end

endmodule
